// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM states, default widths
// and the MIPS ALU control codes used by requesters.
package alu_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/alu_arbiter_rr_grant.sv
// Combinational requester picker: round-robin from rr_ptr, or strict
// lowest-index priority when ALU_ARB_PRIO_EN is defined.
module rr_grant #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

`ifdef ALU_ARB_PRIO_EN
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = |req;
    // Walk downwards so the lowest set index is the last one written.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end
`else
  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = |req;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters; one op in flight,
// accept -> ISSUE -> RESP, min 3 cycles. ALU_ARB_PRIO_EN selects fixed priority.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CTRL_W  = CTRL_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*CTRL_W-1:0] req_ctrl,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [CTRL_W-1:0]         alu_ctrl,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic [DATA_W-1:0]         alu_result,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     gnt_idx;
  logic [NUM_REQ-1:0]   gnt_oh;
  logic [NUM_REQ-1:0]   g_oh;
  logic                 any_req;
  logic                 accept;
  logic                 done;
  logic [CTRL_W-1:0]    sel_ctrl;
  logic [DATA_W-1:0]    sel_a;
  logic [DATA_W-1:0]    sel_b;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_grant (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (gnt_oh),
    .grant_idx (gnt_idx),
    .any_req   (any_req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_RESP;
      ST_RESP:  if (done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign accept    = (state == ST_IDLE) && any_req;
  // rsp_valid carries only the granted bit in RESP, so this ignores other indices.
  assign done      = (state == ST_RESP) && |(rsp_ready & rsp_valid);
  assign req_ready = (rst_n && state == ST_IDLE) ? gnt_oh : '0;
  assign busy      = (state != ST_IDLE);

  always_comb begin
    sel_ctrl = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        sel_ctrl = req_ctrl[i*CTRL_W +: CTRL_W];
        sel_a    = req_a[i*DATA_W +: DATA_W];
        sel_b    = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

`ifndef ALU_ARB_PRIO_EN
  logic [IDX_W-1:0] ptr_nxt;

  always_comb begin
    ptr_nxt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g_oh[i]) ptr_nxt = IDX_W'((i + 1) % NUM_REQ);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ctrl  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_data  <= '0;
      rsp_valid <= '0;
      g_oh      <= '0;
      rr_ptr    <= '0;
    end else begin
      if (accept) begin
        alu_ctrl <= sel_ctrl;
        alu_a    <= sel_a;
        alu_b    <= sel_b;
        g_oh     <= gnt_oh;
      end
      if (state == ST_ISSUE) begin
        rsp_data  <= alu_result;
        rsp_valid <= g_oh;
      end
      if (done) begin
        rsp_valid <= '0;
`ifdef ALU_ARB_PRIO_EN
        rr_ptr    <= '0;
`else
        rr_ptr    <= ptr_nxt;
`endif
      end
    end
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational 32-bit MIPS ALU between NUM_REQ requesters, e.g. the main datapath, a branch-compare unit and a multiply/divide sequencer.
- Each requester presents a control code and two operands over a valid/ready handshake. The block grants one requester at a time, drives the ALU from registered inputs, captures the result and returns it on a per-requester response handshake.
- It sits between the requesters and the ALU instance. The ALU ports are wired straight through: alu_ctrl→ALUControl, alu_a→rs, alu_b→rt, ALUresult→alu_result.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- DATA_W, 32, operand/result width.
- CTRL_W, 4, ALU control code width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester request accepted.
- req_ctrl  input  NUM_REQ*CTRL_W  flattened control codes; requester i occupies bits [i*CTRL_W +: CTRL_W].
- req_a  input  NUM_REQ*DATA_W  flattened operand A (rs).
- req_b  input  NUM_REQ*DATA_W  flattened operand B (rt).
- rsp_valid  output  NUM_REQ  per-requester result valid.
- rsp_ready  input  NUM_REQ  per-requester result consumed.
- rsp_data  output  DATA_W  result, shared by all requesters; qualified by rsp_valid.
- alu_ctrl  output  CTRL_W  to ALU ALUControl.
- alu_a  output  DATA_W  to ALU rs.
- alu_b  output  DATA_W  to ALU rt.
- alu_result  input  DATA_W  from ALU ALUresult.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; alu_ctrl, alu_a, alu_b, rsp_data = 0; rsp_valid = 0; rr_ptr = 0; busy = 0. req_ready is 0 while in reset.
- FSM states: IDLE → ISSUE → RESP → IDLE.
- IDLE:
  - Grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready[grant]=1 combinationally in the same cycle; all other req_ready bits are 0. req_ready is only ever high in IDLE.
  - On that edge: latch req_ctrl/a/b of the grant into alu_ctrl/alu_a/alu_b; store grant index g; go to ISSUE.
  - No req_valid: stay in IDLE, hold all registers.
- ISSUE: the ALU has settled; capture alu_result into rsp_data; set rsp_valid[g]=1; go to RESP.
- RESP:
  - Hold rsp_valid[g] and rsp_data stable until rsp_ready[g]=1.
  - On that edge: clear rsp_valid; rr_ptr=(g+1) mod NUM_REQ; go to IDLE.
- Latency: accept at cycle 0, rsp_valid from cycle 2. Minimum 3 cycles per operation; no pipelining, one op in flight.
- alu_ctrl/alu_a/alu_b hold their last values outside ISSUE; they are never driven with X.
- Requests arriving while busy wait. A requester must hold req_valid and its payload until req_ready. A valid dropped before grant is simply not served.
- rsp_ready asserted for a non-granted index, or outside RESP, is ignored.
- rsp_ready already high on the cycle rsp_valid rises: the transaction completes on the next edge. rsp_valid is high for exactly one cycle.
- All NUM_REQ valid continuously: strict rotation 0,1,…,NUM_REQ-1,0,…
- Reset mid-operation: the transaction is discarded, no response is issued, and rr_ptr returns to 0.

Optional Feature:
- ALU_ARB_PRIO_EN defined: requester 0 has strict priority. The grant is the lowest index with req_valid set; rr_ptr is unused and held at 0.
- Not defined: round-robin as above.

Decomposition:
- Shared package alu_arb_pkg holds:
  - constants DATA_W_DEF=32, CTRL_W_DEF=4;
  - state enum {ST_IDLE, ST_ISSUE, ST_RESP};
  - ALU control code constants reused by requesters and bench.
- One sub-module, rr_grant: combinational round-robin picker. Inputs: req vector, rr_ptr. Outputs: one-hot grant, grant index, any_req. The ALU_ARB_PRIO_EN selection is placed here.

Test Plan:
- Bench ALU model: alu_result = alu_a + alu_b when alu_ctrl=4'b0010, else alu_a − alu_b.
- Reset: rst_n=0 asserted mid-cycle → all outputs 0 immediately, busy=0.
- Single request: req 0, ctrl=4'b0010, a=5, b=3, rsp_ready tied 1 → req_ready[0] at cycle 0, rsp_valid[0] at cycle 2 with rsp_data=8, then back to IDLE.
- Contention: req 0 and req 1 valid from cycle 0 (0: 4'b0010, 7, 1; 1: 4'b0110, 9, 4) → grant 0 first (rsp 8), then 1 (rsp 5). Repeat with both still valid → order 0,1,0,1.
- Backpressure: rsp_ready[0]=0 for 5 cycles → rsp_valid[0] and rsp_data=8 held stable, req_ready stays 0 for the waiting req 1, busy=1.
- Mid-operation reset: rst_n pulsed low during RESP → rsp_valid cleared; after release, req 1 alone is granted with rr_ptr=0.
- ALU_ARB_PRIO_EN build: req 0 and req 1 held valid continuously → req 0 granted every time, req 1 never granted.
